// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and the pixel-memory arbiter state type.
package vga_timing_pkg;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_TOTAL   = 800;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned LOOKAHEAD = 2;

  typedef enum logic [1:0] {
    ST_DISP,
    ST_WRITE,
    ST_ACK
  } arb_state_t;
endpackage

// File: rtl/raster_lookahead.sv
// Combinational raster position + AHEAD with column/row wrap and visible-area flag.
module raster_lookahead
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = H_TOTAL,
  parameter int unsigned TOTAL_ROWS  = V_TOTAL,
  parameter int unsigned ACTIVE_COLS = H_ACTIVE,
  parameter int unsigned ACTIVE_ROWS = V_ACTIVE,
  parameter int unsigned AHEAD       = LOOKAHEAD
) (
  input  logic [9:0] i_Col,
  input  logic [9:0] i_Row,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row,
  output logic       o_Visible
);
  logic [10:0] col_sum;
  logic [10:0] row_sum;

  // AHEAD is smaller than a line, so at most one column wrap per step.
  always_comb begin
    col_sum = {1'b0, i_Col} + 11'(AHEAD);
    row_sum = {1'b0, i_Row};
    if (col_sum >= 11'(TOTAL_COLS)) begin
      col_sum = col_sum - 11'(TOTAL_COLS);
      row_sum = row_sum + 11'd1;
    end
    if (row_sum >= 11'(TOTAL_ROWS)) begin
      row_sum = '0;
    end
    o_Col     = col_sum[9:0];
    o_Row     = row_sum[9:0];
    o_Visible = (o_Col < 10'(ACTIVE_COLS)) && (o_Row < 10'(ACTIVE_ROWS));
  end
endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares a single-port pixel memory between VGA scanout (reads two pixels
// ahead of the raster count) and a pixel writer that only gets idle slots.
module vga_mem_arbiter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = H_TOTAL,
  parameter int unsigned TOTAL_ROWS  = V_TOTAL,
  parameter int unsigned ACTIVE_COLS = H_ACTIVE,
  parameter int unsigned ACTIVE_ROWS = V_ACTIVE,
  parameter int unsigned ADDR_WIDTH  = 19,
  parameter int unsigned DATA_WIDTH  = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [9:0]            CountCol,
  input  logic [9:0]            CountRow,
  input  logic                  i_Wr_Req,
  input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
  input  logic [DATA_WIDTH-1:0] i_Wr_Data,
  output logic                  o_Wr_Ack,
  output logic                  o_Mem_En,
  output logic                  o_Mem_We,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [DATA_WIDTH-1:0] o_Mem_WData,
  input  logic [DATA_WIDTH-1:0] i_Mem_RData,
  output logic [DATA_WIDTH-1:0] o_Pixel_Data,
  output logic                  o_Pixel_Valid,
  output logic                  o_Frame_Start
);
  arb_state_t            state, state_next;
  logic [9:0]            la_col, la_row;
  logic                  fetch, la_origin, wr_issue;
  logic [ADDR_WIDTH-1:0] rd_addr, fetch_addr;
  logic                  vis_d1, vis_d2, fs_d1, fs_d2, ack_q;
  logic [DATA_WIDTH-1:0] pix_q;

  raster_lookahead #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS),
    .ACTIVE_COLS(ACTIVE_COLS),
    .ACTIVE_ROWS(ACTIVE_ROWS),
    .AHEAD      (LOOKAHEAD)
  ) u_lookahead (
    .i_Col    (CountCol),
    .i_Row    (CountRow),
    .o_Col    (la_col),
    .o_Row    (la_row),
    .o_Visible(fetch)
  );

  assign la_origin  = (la_col == '0) && (la_row == '0);
  assign fetch_addr = la_origin ? '0 : rd_addr;

  always_comb begin
    state_next = state;
    wr_issue   = 1'b0;
    case (state)
      ST_DISP: begin
        if (!fetch && i_Wr_Req) begin
          wr_issue   = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: state_next = ST_ACK;
      ST_ACK:   state_next = ST_DISP;
      default:  state_next = ST_DISP;
    endcase
  end

  // Port drive is combinational from the count so a read returns in time;
  // gating with RST keeps every output at 0 while reset is asserted.
  always_comb begin
    o_Mem_En    = 1'b0;
    o_Mem_We    = 1'b0;
    o_Mem_Addr  = '0;
    o_Mem_WData = '0;
    if (!RST) begin
      if (fetch) begin
        o_Mem_En   = 1'b1;
        o_Mem_Addr = fetch_addr;
      end else if (wr_issue) begin
        o_Mem_En    = 1'b1;
        o_Mem_We    = 1'b1;
        o_Mem_Addr  = i_Wr_Addr;
        o_Mem_WData = i_Wr_Data;
      end
    end
  end

  // Ack is registered off ST_WRITE, so it appears once the write has settled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_DISP;
      rd_addr <= '0;
      vis_d1  <= 1'b0;
      vis_d2  <= 1'b0;
      fs_d1   <= 1'b0;
      fs_d2   <= 1'b0;
      pix_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (fetch) begin
        rd_addr <= fetch_addr + ADDR_WIDTH'(1);
      end
      vis_d1 <= fetch;
      fs_d1  <= fetch && la_origin;
      vis_d2 <= vis_d1;
      fs_d2  <= fs_d1;
      pix_q  <= vis_d1 ? i_Mem_RData : '0;
      ack_q  <= (state == ST_WRITE);
    end
  end

  assign o_Pixel_Data  = pix_q;
  assign o_Pixel_Valid = vis_d2;
  assign o_Frame_Start = fs_d2;
  assign o_Wr_Ack      = ack_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: drives raster counts and writes, models the memory.
module tb_vga_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic [9:0]  CountCol, CountRow;
  logic        i_Wr_Req;
  logic [18:0] i_Wr_Addr;
  logic [11:0] i_Wr_Data;
  logic        o_Wr_Ack, o_Mem_En, o_Mem_We;
  logic [18:0] o_Mem_Addr;
  logic [11:0] o_Mem_WData, i_Mem_RData, o_Pixel_Data;
  logic        o_Pixel_Valid, o_Frame_Start;

  logic [11:0] mem [0:(1<<19)-1];

  typedef struct {logic v; logic fs; logic [11:0] d; logic [9:0] r; logic [9:0] c;} pix_t;
  typedef struct {logic [18:0] a; logic [11:0] d;} wr_t;
  pix_t pix_q[$];
  wr_t  wr_q[$];
  int   wr_cols[$];
  logic [9:0] last_wr_row, last_ack_col, last_ack_row;
  int   ack_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   chk_en = 0;

  vga_mem_arbiter #(
    .TOTAL_COLS(800), .TOTAL_ROWS(525), .ACTIVE_COLS(640), .ACTIVE_ROWS(480),
    .ADDR_WIDTH(19), .DATA_WIDTH(12)
  ) dut (
    .CLK(CLK), .RST(RST), .CountCol(CountCol), .CountRow(CountRow),
    .i_Wr_Req(i_Wr_Req), .i_Wr_Addr(i_Wr_Addr), .i_Wr_Data(i_Wr_Data),
    .o_Wr_Ack(o_Wr_Ack), .o_Mem_En(o_Mem_En), .o_Mem_We(o_Mem_We),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_WData(o_Mem_WData), .i_Mem_RData(i_Mem_RData),
    .o_Pixel_Data(o_Pixel_Data), .o_Pixel_Valid(o_Pixel_Valid), .o_Frame_Start(o_Frame_Start)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port memory, read data one cycle after the request.
  always @(posedge CLK) begin
    if (o_Mem_En === 1'b1) begin
      if (o_Mem_We === 1'b1) mem[o_Mem_Addr] <= o_Mem_WData;
      else                   i_Mem_RData <= mem[o_Mem_Addr];
    end
  end

  task automatic push_pix();
    pix_t e;
    int idx;
    e.r  = CountRow;
    e.c  = CountCol;
    e.v  = (CountCol < 10'd640) && (CountRow < 10'd480);
    e.fs = (CountCol == 10'd0) && (CountRow == 10'd0);
    idx  = int'(CountRow) * 640 + int'(CountCol);
    e.d  = e.v ? mem[idx] : 12'h000;
    pix_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (CountCol == 10'd799) begin
      CountCol = 10'd0;
      CountRow = (CountRow == 10'd524) ? 10'd0 : CountRow + 10'd1;
    end else begin
      CountCol = CountCol + 10'd1;
    end
    if (chk_en) push_pix();
  endtask

  task automatic jump(input logic [9:0] r, input logic [9:0] c);
    @(posedge CLK);
    #1;
    CountRow = r;
    CountCol = c;
    if (chk_en) push_pix();
  endtask

  task automatic run_to(input logic [9:0] r, input logic [9:0] c);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (CountRow == r && CountCol == c) break;
      tick();
    end
    n_tests++;
    if (CountRow != r || CountCol != c) begin
      n_fail++;
      $display("FAIL run_to: reached r%0d c%0d, required r%0d c%0d", CountRow, CountCol, r, c);
    end
  endtask

  task automatic write_one(input logic [18:0] a, input logic [11:0] d, input int budget);
    wr_t w;
    int  s;
    bit  got;
    w.a = a;
    w.d = d;
    wr_q.push_back(w);
    i_Wr_Req  = 1'b1;
    i_Wr_Addr = a;
    i_Wr_Data = d;
    s   = ack_cnt;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      #1;
      if (ack_cnt != s) begin
        got = 1;
        break;
      end
      tick();
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL write_ack_timeout: no ack within %0d cycles for addr %h", budget, a);
    end
    tick();
    i_Wr_Req = 1'b0;
  endtask

  // Per-cycle monitor: pixel scoreboard, lookahead read checks, write scoreboard, acks.
  always @(negedge CLK) begin : mon
    pix_t e;
    wr_t  w;
    int   lc, lr;
    if (chk_en && pix_q.size() > 0) begin
      e = pix_q.pop_front();
      n_tests++;
      if ({o_Pixel_Valid, o_Frame_Start, o_Pixel_Data} !== {e.v, e.fs, e.d}) begin
        n_fail++;
        $display("FAIL pixel r%0d c%0d: got v=%0b fs=%0b d=%h, required v=%0b fs=%0b d=%h",
                 e.r, e.c, o_Pixel_Valid, o_Frame_Start, o_Pixel_Data, e.v, e.fs, e.d);
      end
    end
    if (chk_en) begin
      lc = int'(CountCol) + 2;
      lr = int'(CountRow);
      if (lc >= 800) begin
        lc -= 800;
        lr++;
        if (lr >= 525) lr = 0;
      end
      if (lc < 640 && lr < 480) begin
        n_tests++;
        if ({o_Mem_En, o_Mem_We, o_Mem_Addr} !== {1'b1, 1'b0, 19'(lr * 640 + lc)}) begin
          n_fail++;
          $display("FAIL fetch r%0d c%0d: got en=%0b we=%0b addr=%0d, required en=1 we=0 addr=%0d",
                   CountRow, CountCol, o_Mem_En, o_Mem_We, o_Mem_Addr, lr * 640 + lc);
        end
      end
    end
    if (RST === 1'b0 && o_Mem_En === 1'b1 && o_Mem_We === 1'b1) begin
      n_tests++;
      wr_cols.push_back(int'(CountCol));
      last_wr_row = CountRow;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got addr=%h data=%h at r%0d c%0d, required no write",
                 o_Mem_Addr, o_Mem_WData, CountRow, CountCol);
      end else begin
        w = wr_q.pop_front();
        if ({o_Mem_Addr, o_Mem_WData} !== {w.a, w.d}) begin
          n_fail++;
          $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                   o_Mem_Addr, o_Mem_WData, w.a, w.d);
        end
      end
    end
    if (o_Wr_Ack === 1'b1) begin
      ack_cnt++;
      last_ack_col = CountCol;
      last_ack_row = CountRow;
    end
  end

  task automatic test_reset();
    RST = 1'b1;
    CountCol = 10'd0;
    CountRow = 10'd0;
    i_Wr_Req = 1'b0;
    i_Wr_Addr = '0;
    i_Wr_Data = '0;
    #12;
    n_tests++;
    if ({o_Wr_Ack, o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_WData, o_Pixel_Data, o_Pixel_Valid, o_Frame_Start} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%0b we=%0b addr=%h ack=%0b pix=%h v=%0b fs=%0b, required all 0",
               o_Mem_En, o_Mem_We, o_Mem_Addr, o_Wr_Ack, o_Pixel_Data, o_Pixel_Valid, o_Frame_Start);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    CountRow = 10'd524;
    CountCol = 10'd790;
    chk_en = 1;
    push_pix();
  endtask

  task automatic test_wrap();
    run_to(10'd524, 10'd798);
    @(negedge CLK);
    #1;
    n_tests++;
    if ({o_Mem_En, o_Mem_We, o_Mem_Addr} !== {1'b1, 1'b0, 19'd0}) begin
      n_fail++;
      $display("FAIL wrap_fetch: got en=%0b we=%0b addr=%0d, required en=1 we=0 addr=0", o_Mem_En, o_Mem_We, o_Mem_Addr);
    end
    tick();
    tick();
    @(negedge CLK);
    #1;
    n_tests++;
    if ({o_Frame_Start, o_Pixel_Valid, o_Pixel_Data} !== {1'b1, 1'b1, 12'h000}) begin
      n_fail++;
      $display("FAIL wrap_origin: got fs=%0b v=%0b d=%h, required fs=1 v=1 d=000", o_Frame_Start, o_Pixel_Valid, o_Pixel_Data);
    end
  endtask

  task automatic test_blank_write();
    run_to(10'd0, 10'd700);
    wr_cols.delete();
    write_one(19'd10, 12'hABC, 20);
    n_tests++;
    if (wr_cols.size() != 1 || wr_cols[0] != 700 || last_ack_col != 10'd702) begin
      n_fail++;
      $display("FAIL blank_write_timing: got writes=%0d first_col=%0d ack_col=%0d, required writes=1 col=700 ack_col=702",
               wr_cols.size(), (wr_cols.size() > 0) ? wr_cols[0] : -1, last_ack_col);
    end
  endtask

  task automatic test_back_to_back();
    wr_t w;
    int  s;
    run_to(10'd0, 10'd710);
    wr_cols.delete();
    s = ack_cnt;
    w.a = 19'd20;
    w.d = 12'h123;
    repeat (3) wr_q.push_back(w);
    i_Wr_Req  = 1'b1;
    i_Wr_Addr = w.a;
    i_Wr_Data = w.d;
    repeat (8) tick();
    tick();
    i_Wr_Req = 1'b0;
    repeat (6) tick();
    @(negedge CLK);
    #1;
    n_tests++;
    if (wr_cols.size() != 3 || wr_cols[0] != 710 || wr_cols[1] != 713 || wr_cols[2] != 716 || ack_cnt - s != 3) begin
      n_fail++;
      $display("FAIL held_request: got writes=%0d acks=%0d, required writes at cols 710,713,716 and 3 acks",
               wr_cols.size(), ack_cnt - s);
    end
  endtask

  task automatic test_scanout();
    run_to(10'd1, 10'd5);
    @(negedge CLK);
    #1;
    n_tests++;
    if ({o_Pixel_Valid, o_Pixel_Data} !== {1'b1, 12'd645}) begin
      n_fail++;
      $display("FAIL scanout_r1c5: got v=%0b d=%0d, required v=1 d=645", o_Pixel_Valid, o_Pixel_Data);
    end
    run_to(10'd1, 10'd640);
    @(negedge CLK);
    #1;
    n_tests++;
    if ({o_Pixel_Valid, o_Pixel_Data} !== {1'b0, 12'd0}) begin
      n_fail++;
      $display("FAIL scanout_c640: got v=%0b d=%0d, required v=0 d=0", o_Pixel_Valid, o_Pixel_Data);
    end
  endtask

  task automatic test_defer();
    run_to(10'd3, 10'd100);
    wr_cols.delete();
    write_one(19'd30, 12'h5A5, 700);
    n_tests++;
    if (wr_cols.size() != 1 || wr_cols[0] != 638 || last_wr_row != 10'd3 ||
        last_ack_col != 10'd640 || last_ack_row != 10'd3) begin
      n_fail++;
      $display("FAIL defer_timing: got writes=%0d col=%0d ack r%0d c%0d, required 1 write at r3 c638, ack r3 c640",
               wr_cols.size(), (wr_cols.size() > 0) ? wr_cols[0] : -1, last_ack_row, last_ack_col);
    end
  endtask

  task automatic test_vblank_write();
    jump(10'd500, 10'd100);
    wr_cols.delete();
    write_one(19'h7FFFF, 12'hFED, 20);
    n_tests++;
    if (wr_cols.size() != 1 || wr_cols[0] != 100 || last_ack_col != 10'd102) begin
      n_fail++;
      $display("FAIL vblank_write: got writes=%0d col=%0d ack_col=%0d, required 1 write at c100, ack c102",
               wr_cols.size(), (wr_cols.size() > 0) ? wr_cols[0] : -1, last_ack_col);
    end
  endtask

  task automatic test_next_frame();
    jump(10'd524, 10'd790);
    run_to(10'd0, 10'd10);
    @(negedge CLK);
    #1;
    n_tests++;
    if ({o_Pixel_Valid, o_Pixel_Data} !== {1'b1, 12'hABC}) begin
      n_fail++;
      $display("FAIL written_pixel: got v=%0b d=%h, required v=1 d=abc", o_Pixel_Valid, o_Pixel_Data);
    end
  endtask

  task automatic test_reset_mid();
    run_to(10'd0, 10'd300);
    chk_en = 0;
    pix_q.delete();
    #2;
    RST = 1'b1;
    #1;
    n_tests++;
    if ({o_Wr_Ack, o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_WData, o_Pixel_Data, o_Pixel_Valid, o_Frame_Start} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got en=%0b we=%0b addr=%h pix=%h v=%0b fs=%0b, required all 0",
               o_Mem_En, o_Mem_We, o_Mem_Addr, o_Pixel_Data, o_Pixel_Valid, o_Frame_Start);
    end
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    CountRow = 10'd524;
    CountCol = 10'd790;
    chk_en = 1;
    push_pix();
    run_to(10'd0, 10'd0);
    @(negedge CLK);
    #1;
    n_tests++;
    if ({o_Frame_Start, o_Pixel_Valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_resync: got fs=%0b v=%0b at r0 c0, required fs=1 v=1", o_Frame_Start, o_Pixel_Valid);
    end
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << 19); i++) mem[i] = i[11:0];
    test_reset();
    test_wrap();
    test_blank_write();
    test_back_to_back();
    test_scanout();
    test_defer();
    test_vblank_write();
    test_next_frame();
    test_reset_mid();
    n_tests++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_writes: got %0d writes never issued, required 0", wr_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
